// File: rtl/asip_frontend_pkg.sv
// Shared types and defaults for the ASIP board-input front end.
package asip_frontend_pkg;

   typedef enum logic [1:0] {
      WAIT_REL = 2'd0,
      IDLE     = 2'd1,
      RUN      = 2'd2
   } state_t;

   localparam int DEF_NUM_CH          = 3;
   localparam int DEF_CH_W            = 2;
   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 4;

   // Width of a counter that must hold values up to DEBOUNCE_CYCLES.
   function automatic int debounce_cnt_w(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/asip_switch_frontend_if.sv
// Board-side switches in, frozen run configuration and start/done strobes out.
//
// Handshake: start_pulse is a single-cycle strobe issued when a run begins; the
// configuration on color_sel/gtype_sel is stable for the whole run (running=1)
// and the run ends at the first clock edge where done_i is sampled high.
// There is no back-pressure: the core must accept start_pulse when it appears.
interface asip_switch_frontend_if
   import asip_frontend_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int CH_W   = DEF_CH_W
) ();

   logic [NUM_CH*CH_W-1:0] color_switches;
   logic                   gtype_switch;
   logic                   switchStart;
   logic                   done_i;
   logic [NUM_CH*CH_W-1:0] color_sel;
   logic                   gtype_sel;
   logic                   start_pulse;
   logic                   running;
   logic                   config_changed;
   state_t                 state_dbg;

   modport master (
      output color_switches, gtype_switch, switchStart, done_i,
      input  color_sel, gtype_sel, start_pulse, running, config_changed, state_dbg
   );

   modport slave (
      input  color_switches, gtype_switch, switchStart, done_i,
      output color_sel, gtype_sel, start_pulse, running, config_changed, state_dbg
   );

endinterface

// File: rtl/switch_debouncer.sv
// Single-bit synchroniser followed by a consecutive-disagreement debounce counter.
module switch_debouncer
   import asip_frontend_pkg::*;
#(
   parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic deb
);

   localparam int             CW      = debounce_cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q;

   // Shift the raw input through the synchroniser chain.
   always_ff @(posedge clk) begin
      if (rst) sync_q <= {SYNC_STAGES{RESET_VAL}};
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
   end

   // Flip the debounced bit only after DEBOUNCE_CYCLES consecutive disagreements.
   always_ff @(posedge clk) begin
      if (rst) begin
         deb   <= RESET_VAL;
         cnt_q <= '0;
      end else if (sync_q[SYNC_STAGES-1] == deb) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
         deb   <= ~deb;
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/asip_switch_frontend.sv
// Debounces the board switches and start button, issues the start strobe and
// freezes the run configuration until the core reports done.
module asip_switch_frontend
   import asip_frontend_pkg::*;
#(
   parameter int NUM_CH          = DEF_NUM_CH,
   parameter int CH_W            = DEF_CH_W,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input logic                   clk,
   input logic                   rst,
   asip_switch_frontend_if.slave bus
);

   localparam int SW_W  = NUM_CH * CH_W;
   localparam int CFG_W = SW_W + 1;   // colour bits plus gtype
   localparam int NB    = SW_W + 2;   // plus the start button

   logic [NB-1:0]    raw_bits;
   logic [NB-1:0]    deb_bits;
   logic [CFG_W-1:0] deb_cfg;
   logic [CFG_W-1:0] deb_cfg_q;
   logic [CFG_W-1:0] sel_q;
   logic             deb_start;
   logic             deb_start_q;
   logic             start_fall;
   logic             cfg_flip;

   state_t state_q;
   state_t state_n;
   logic   pulse_n;
   logic   cc_n;
   logic   load_cfg;
   logic   start_pulse_q;
   logic   config_changed_q;
   logic   running_q;

   assign raw_bits = {bus.switchStart, bus.gtype_switch, bus.color_switches};

   for (genvar i = 0; i < NB; i++) begin : g_deb
      switch_debouncer #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL       (1'b0)
      ) u_deb (
         .clk (clk),
         .rst (rst),
         .raw (raw_bits[i]),
         .deb (deb_bits[i])
      );
   end

   assign deb_cfg    = deb_bits[CFG_W-1:0];
   assign deb_start  = deb_bits[NB-1];
   assign start_fall = deb_start_q & ~deb_start;   // active-low button pressed
   assign cfg_flip   = (deb_cfg != deb_cfg_q);

   // Remember last cycle's debounced values for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         deb_start_q <= 1'b0;
         deb_cfg_q   <= '0;
      end else begin
         deb_start_q <= deb_start;
         deb_cfg_q   <= deb_cfg;
      end
   end

   // Next state, strobes and config-load enable; RUN holds the frozen config.
   always_comb begin
      state_n  = state_q;
      pulse_n  = 1'b0;
      cc_n     = 1'b0;
      load_cfg = 1'b0;
      case (state_q)
         WAIT_REL: begin
            load_cfg = 1'b1;
            if (deb_start) state_n = IDLE;
         end
         IDLE: begin
            load_cfg = 1'b1;
            if (start_fall) begin
               state_n = RUN;
               pulse_n = 1'b1;
            end else begin
               cc_n = cfg_flip;
            end
         end
         RUN: begin
            // done wins over any start edge seen in the same cycle
            if (bus.done_i) begin
               state_n  = IDLE;
               load_cfg = 1'b1;
            end
         end
         default: state_n = WAIT_REL;
      endcase
   end

   // State register and registered strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= WAIT_REL;
         start_pulse_q    <= 1'b0;
         config_changed_q <= 1'b0;
         running_q        <= 1'b0;
      end else begin
         state_q          <= state_n;
         start_pulse_q    <= pulse_n;
         config_changed_q <= cc_n;
         running_q        <= (state_n == RUN);
      end
   end

   // Track debounced config outside a run; latch it on entry to RUN.
   always_ff @(posedge clk) begin
      if (rst)           sel_q <= '0;
      else if (load_cfg) sel_q <= deb_cfg;
   end

   assign bus.color_sel      = sel_q[SW_W-1:0];
   assign bus.gtype_sel      = sel_q[SW_W];
   assign bus.start_pulse    = start_pulse_q;
   assign bus.running        = running_q;
   assign bus.config_changed = config_changed_q;
   assign bus.state_dbg      = state_q;

endmodule

// File: tb/tb_asip_switch_frontend.sv
// Directed plus randomised checks of the switch front end against a
// window-based reference model of synchronise/debounce and the run rules.
module tb_asip_switch_frontend;
   import asip_frontend_pkg::*;

   localparam int NUM_CH = 3;
   localparam int CH_W   = 2;
   localparam int S      = 2;
   localparam int D      = 4;
   localparam int SW_W   = NUM_CH * CH_W;
   localparam int NB     = SW_W + 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   asip_switch_frontend_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

   asip_switch_frontend #(
      .NUM_CH (NUM_CH), .CH_W (CH_W), .SYNC_STAGES (S), .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- counters ----------------
   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // A debounced bit flips at edge e when every raw sample taken at edges
   // e-S-D+1 .. e-S disagrees with it; samples at or before a reset edge read 0.
   logic [NB-1:0]   hist[$];
   int              cyc      = 0;
   int              last_rst = -1000;
   logic [NB-1:0]   m_deb    = '0;
   logic [NB-1:0]   m_deb_q  = '0;
   state_t          m_state  = WAIT_REL;
   logic [SW_W:0]   m_sel    = '0;
   logic            m_pulse  = 1'b0;
   logic            m_run    = 1'b0;
   logic            m_cc     = 1'b0;
   logic [SW_W:0]   exp_q[$];   // config expected to be latched at each start

   function automatic logic sample_bit(input int k, input int b);
      if (k < 0 || k <= last_rst) return 1'b0;
      return hist[k][b];
   endfunction

   task automatic model_edge();
      logic [NB-1:0] raw;
      logic [NB-1:0] nd;
      logic          fall;
      logic          flip;
      bit            all_diff;
      raw = {bus.switchStart, bus.gtype_switch, bus.color_switches};
      if (rst) begin
         hist.push_back('0);
         last_rst = cyc;
         m_deb = '0; m_deb_q = '0; m_state = WAIT_REL; m_sel = '0;
         m_pulse = 1'b0; m_run = 1'b0; m_cc = 1'b0;
      end else begin
         hist.push_back(raw);
         fall    = m_deb_q[NB-1] && !m_deb[NB-1];
         flip    = (m_deb[NB-2:0] != m_deb_q[NB-2:0]);
         m_pulse = 1'b0;
         m_cc    = 1'b0;
         if (m_state == WAIT_REL) begin
            m_sel = m_deb[NB-2:0];
            if (m_deb[NB-1]) m_state = IDLE;
         end else if (m_state == IDLE) begin
            m_sel = m_deb[NB-2:0];
            if (fall) begin
               m_state = RUN;
               m_pulse = 1'b1;
               exp_q.push_back(m_deb[NB-2:0]);
            end else begin
               m_cc = flip;
            end
         end else if (bus.done_i) begin
            m_state = IDLE;
            m_sel   = m_deb[NB-2:0];
         end
         m_run = (m_state == RUN);
         nd = m_deb;
         for (int b = 0; b < NB; b++) begin
            all_diff = 1;
            for (int k = cyc - S - D + 1; k <= cyc - S; k++)
               if (sample_bit(k, b) == m_deb[b]) all_diff = 0;
            if (all_diff) nd[b] = ~m_deb[b];
         end
         m_deb_q = m_deb;
         m_deb   = nd;
      end
      cyc++;
   endtask

   // ---------------- scoreboard: per-cycle comparison ----------------
   task automatic check_all();
      logic [SW_W:0] e;
      chk("state",          32'(bus.state_dbg),      32'(m_state));
      chk("running",        32'(bus.running),        32'(m_run));
      chk("start_pulse",    32'(bus.start_pulse),    32'(m_pulse));
      chk("config_changed", 32'(bus.config_changed), 32'(m_cc));
      chk("color_sel",      32'(bus.color_sel),      32'(m_sel[SW_W-1:0]));
      chk("gtype_sel",      32'(bus.gtype_sel),      32'(m_sel[SW_W]));
      if (bus.start_pulse === 1'b1) begin
         chk("pulse_has_expect", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("latched_cfg", 32'({bus.gtype_sel, bus.color_sel}), 32'(e));
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic count_pulses(input int n, output int p);
      p = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (bus.start_pulse === 1'b1) p++;
      end
   endtask

   // Ticks until the chosen strobe is seen; n = ticks taken, -1 on timeout.
   task automatic run_until(input bit want_pulse, input int max_ticks, output int n);
      n = -1;
      for (int i = 1; i <= max_ticks; i++) begin
         tick();
         if ((want_pulse ? bus.start_pulse : bus.config_changed) === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int p;
      int p2;
      int hold;

      rst = 1'b1;
      bus.color_switches = '0;
      bus.gtype_switch   = 1'b0;
      bus.switchStart    = 1'b1;
      bus.done_i         = 1'b0;

      // reset with button released
      ticks(5);
      chk("rst_running", 32'(bus.running), 32'd0);
      chk("rst_pulse",   32'(bus.start_pulse), 32'd0);
      chk("rst_state",   32'(bus.state_dbg), 32'(WAIT_REL));
      rst = 1'b0;
      ticks(15);
      chk("idle_after_reset", 32'(bus.state_dbg), 32'(IDLE));

      // config change in IDLE
      bus.color_switches = 6'b000001;
      run_until(1'b0, 40, n);
      chk("cfg_latency", 32'(n), 32'd7);
      chk("cfg_sel", 32'(bus.color_sel), 32'd1);
      ticks(3);

      // start press, then switch changes during RUN
      bus.switchStart = 1'b0;
      run_until(1'b1, 40, n);
      chk("start_latency", 32'(n), 32'd7);
      bus.color_switches = 6'h2a;
      bus.gtype_switch   = 1'b1;
      ticks(12);
      chk("frozen_sel",   32'(bus.color_sel), 32'd1);
      chk("frozen_gtype", 32'(bus.gtype_sel), 32'd0);
      bus.switchStart = 1'b1;
      ticks(10);
      bus.done_i = 1'b1;
      tick();
      bus.done_i = 1'b0;
      ticks(3);
      chk("resync_sel", 32'(bus.color_sel), 32'h2a);

      // glitch on start shorter than the debounce depth
      bus.switchStart = 1'b0;
      ticks(3);
      bus.switchStart = 1'b1;
      count_pulses(15, p);
      chk("glitch_pulses",  32'(p), 32'd0);
      chk("glitch_running", 32'(bus.running), 32'd0);

      // done coincident with a debounced start fall in RUN
      bus.switchStart = 1'b0;
      run_until(1'b1, 40, n);
      chk("start2_latency", 32'(n), 32'd7);
      bus.switchStart = 1'b1;
      ticks(10);
      bus.switchStart = 1'b0;
      ticks(6);
      bus.done_i = 1'b1;
      tick();
      p = (bus.start_pulse === 1'b1) ? 1 : 0;
      bus.done_i = 1'b0;
      count_pulses(10, p2);
      chk("coincident_pulses",  32'(p + p2), 32'd0);
      chk("coincident_running", 32'(bus.running), 32'd0);
      bus.switchStart = 1'b1;
      ticks(10);
      bus.switchStart = 1'b0;
      run_until(1'b1, 40, n);
      chk("repress_latency", 32'(n), 32'd7);
      bus.done_i = 1'b1;
      tick();
      bus.done_i = 1'b0;

      // button held through reset and release
      bus.color_switches = 6'h15;
      rst = 1'b1;
      ticks(3);
      rst = 1'b0;
      count_pulses(20, p);
      chk("held_pulses", 32'(p), 32'd0);
      chk("held_state",  32'(bus.state_dbg), 32'(WAIT_REL));
      bus.switchStart = 1'b1;
      ticks(12);
      chk("held_released_state", 32'(bus.state_dbg), 32'(IDLE));
      bus.switchStart = 1'b0;
      run_until(1'b1, 40, n);
      chk("held_start_latency", 32'(n), 32'd7);

      // reset in the middle of a run
      ticks(2);
      rst = 1'b1;
      tick();
      chk("midrun_rst_running", 32'(bus.running), 32'd0);
      chk("midrun_rst_sel",     32'(bus.color_sel), 32'd0);
      rst = 1'b0;
      bus.switchStart = 1'b1;
      ticks(12);

      // randomised segments
      for (int seg = 0; seg < 160; seg++) begin
         bus.color_switches = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 3) == 0) bus.gtype_switch = ~bus.gtype_switch;
         if ($urandom_range(0, 1) == 0) bus.switchStart  = ~bus.switchStart;
         rst  = ($urandom_range(0, 60) == 0);
         hold = $urandom_range(1, 14);
         for (int k = 0; k < hold; k++) begin
            bus.done_i = ($urandom_range(0, 7) == 0);
            tick();
            rst = 1'b0;
         end
      end
      bus.done_i = 1'b0;
      ticks(20);
      chk("pending_starts", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/asip_switch_frontend.md
Name: asip_switch_frontend

Overview:
- Synthesisable board-input front end for the vector ASIP.
- Synchronises and debounces NUM_CH colour-select switch groups, the gtype switch and the active-low start button.
- Generates a one-cycle start pulse and holds the frozen run configuration until the core reports completion.
- Replaces direct wiring of raw switches into the core. It generalises channel count, channel width, debounce depth and synchroniser depth.

Parameters:
- NUM_CH, 3, number of colour-select switch groups (R,G,B by default)
- CH_W, 2, bits per switch group
- SYNC_STAGES, 2, synchroniser flops per input bit (>=2)
- DEBOUNCE_CYCLES, 4, consecutive disagreeing cycles before a debounced bit flips (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- color_switches  in  NUM_CH*CH_W  raw switches; group k = bits [k*CH_W +: CH_W]
- gtype_switch  in  1  raw mode switch
- switchStart  in  1  raw start button, active-low (1 = released)
- done_i  in  1  core finished current run; level, sampled only in RUN
- color_sel  out  NUM_CH*CH_W  debounced/frozen colour selection
- gtype_sel  out  1  debounced/frozen mode
- start_pulse  out  1  one-cycle start strobe to core
- running  out  1  high while in RUN
- config_changed  out  1  one-cycle pulse when any debounced colour/gtype bit changes in IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst). rst sampled high at an edge forces every register to its reset value at that edge, in any state.
- Reset values:
  - color_sel, gtype_sel: 0.
  - start_pulse, running, config_changed: 0.
  - All synchroniser and debounced flops: 0. This includes the start path, so start is treated as pressed.
  - State: WAIT_REL.
- Synchroniser: a raw value first sampled at edge t appears at the synchroniser output after edge t+SYNC_STAGES-1.
- Debounce, per bit:
  - A counter increments each cycle while the synchronised value differs from the debounced value.
  - The counter clears on agreement.
  - When the counter is at DEBOUNCE_CYCLES-1 and the values still differ, the debounced bit flips at that edge and the counter clears.
  - Net latency: a raw change stable from edge t flips the debounced bit at edge t+SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never flips it.
- FSM, states WAIT_REL, IDLE, RUN:
  - WAIT_REL -> IDLE when debounced start = 1. This prevents a start from a button held through reset.
  - IDLE -> RUN on a debounced start falling edge (1->0):
    - start_pulse = 1 for exactly one cycle, on the edge after the debounced fall.
    - color_sel/gtype_sel latch the debounced values at that same edge.
    - running = 1 from that edge.
  - RUN -> IDLE when done_i = 1 at an edge; running = 0 from that edge.
  - RUN: further start edges are ignored and discarded. They are not queued; a new press needs release then press in IDLE. Switch changes do not affect color_sel/gtype_sel.
- IDLE outputs:
  - color_sel/gtype_sel follow the debounced values, registered one cycle after the debounced flip.
  - config_changed pulses on that same cycle. Multiple simultaneous bit changes give a single pulse.
  - No config_changed in WAIT_REL or RUN.
  - On the RUN->IDLE edge, outputs resume tracking and no config_changed pulse is issued for that resync.
- Simultaneous events:
  - done_i and a debounced start fall in the same RUN cycle: done wins, and the start edge is discarded.
  - A start fall and a config change in the same IDLE cycle: start wins, no config_changed, and the new config is latched.

Decomposition:
- asip_frontend_pkg holds:
  - The state enum (WAIT_REL, IDLE, RUN).
  - Default parameter constants.
  - A function returning the counter width, $clog2(DEBOUNCE_CYCLES+1).
- One sub-module, switch_debouncer (single bit: synchroniser + counter, parameters SYNC_STAGES, DEBOUNCE_CYCLES, RESET_VAL). It is instantiated via generate for NUM_CH*CH_W+2 bits.

Test Plan:
- Defaults, rst=1 for 5 cycles with switchStart=1, then rst=0 -> running=0, start_pulse=0, state IDLE once debounced start=1 after edge 5.
- In IDLE, color_switches 6'b000000->6'b000001 stable from edge t -> color_sel=6'b000001 and config_changed=1 for one cycle after edge t+6.
- In IDLE, switchStart 1->0 stable from edge t -> start_pulse high exactly one cycle after edge t+6; running=1; color_sel frozen. Changing switches during RUN leaves color_sel unchanged.
- Glitch: switchStart low for 3 cycles only -> no start_pulse, running stays 0.
- RUN, done_i=1 coincident with a debounced start fall -> running=0 next edge, no start_pulse; second press after release -> one start_pulse.
- switchStart=0 held through reset and release -> stays in WAIT_REL, no start_pulse until released then pressed. Also: rst=1 mid-RUN -> running=0 and color_sel=0 at that edge.
